// File: rtl/bounce_pkg.sv
// Shared types and default constants for the bounce difficulty scheduler.
package bounce_pkg;

  localparam int SPEED_W = 4;
  localparam int LEVEL_W = 4;
  localparam int HITC_W  = 4;
  localparam int FDIV_W  = 6;

  localparam int DEF_HITS_PER_LEVEL = 5;
  localparam int DEF_MAX_LEVEL      = 9;
  localparam int DEF_BASE_SPEED     = 1;
  localparam int DEF_RAMP_FRAMES    = 30;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    RAMP = 2'b10,
    HOLD = 2'b11
  } state_t;

endpackage

// File: rtl/bounce_frame_div.sv
// Clearable modulo-RAMP_FRAMES counter on qualified frame ticks; step_o marks
// the tick that wraps the count.
module bounce_frame_div
  import bounce_pkg::*;
#(
  parameter int RAMP_FRAMES = DEF_RAMP_FRAMES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  output logic              step_o,
  output logic [FDIV_W-1:0] cnt_o
);

  localparam logic [FDIV_W-1:0] LAST = FDIV_W'(RAMP_FRAMES - 1);

  logic [FDIV_W-1:0] cnt_q;
  logic [FDIV_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap on enabled ticks.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign step_o = en_i && !clr_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/bounce_level_ctrl.sv
// Difficulty scheduler: counts hits, advances level every HITS_PER_LEVEL hits,
// and ramps ball speed one step per RAMP_FRAMES frame ticks toward the target.
module bounce_level_ctrl
  import bounce_pkg::*;
#(
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter int BASE_SPEED     = DEF_BASE_SPEED,
  parameter int RAMP_FRAMES    = DEF_RAMP_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               run,
  input  logic               game_clr,
  input  logic               hit,
  input  logic               miss,
  output logic [SPEED_W-1:0] speed,
  output logic [LEVEL_W-1:0] level,
  output logic               level_up,
  output logic               ramping
);

  localparam logic [HITC_W-1:0]  HIT_LAST = HITC_W'(HITS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [SPEED_W-1:0] BASE     = SPEED_W'(BASE_SPEED);

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [HITC_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic               level_up_q, level_up_d;
  logic               ramping_q, ramping_d;

  logic               div_en;
  logic               div_clr;
  logic               div_step;
  logic [FDIV_W-1:0]  div_cnt;
  logic               lvl_wrap;

  // A hit that completes the group while the level can still rise.
  assign lvl_wrap = hit && (hit_cnt_q == HIT_LAST) && (level_q < LVL_MAX);

  // Frame ticks only advance the divider while actively ramping; the divider
  // restarts on a level-up out of RUN (not during RAMP) and on game clear.
  assign div_en  = (state_q == RAMP) && run && frame_tick && !miss && !game_clr;
  assign div_clr = game_clr || ((state_q == RUN) && !miss && lvl_wrap);

  bounce_frame_div #(
    .RAMP_FRAMES (RAMP_FRAMES)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (div_clr),
    .en_i   (div_en),
    .step_o (div_step),
    .cnt_o  (div_cnt)
  );

  // Next-state: game_clr > miss > hit > run/frame_tick.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    hit_cnt_d  = hit_cnt_q;
    speed_d    = speed_q;
    target_d   = target_q;
    level_up_d = 1'b0;

    if (game_clr) begin
      state_d   = IDLE;
      level_d   = '0;
      hit_cnt_d = '0;
      speed_d   = BASE;
      target_d  = BASE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) state_d = RUN;
        end
        RUN, RAMP: begin
          if (miss) begin
            state_d = HOLD;
            if (state_q == RAMP) speed_d = target_q;
          end else begin
            if (hit) begin
              if (hit_cnt_q == HIT_LAST) begin
                hit_cnt_d = '0;
                if (level_q < LVL_MAX) begin
                  level_d    = level_q + 1'b1;
                  level_up_d = 1'b1;
                  target_d   = BASE + SPEED_W'(level_d);
                  state_d    = RAMP;
                end
              end else begin
                hit_cnt_d = hit_cnt_q + 1'b1;
              end
            end
            // Target is settled above, so the step-completion test sees any
            // level-up from this same cycle.
            if (!run) begin
              state_d = HOLD;
            end else if (div_step) begin
              speed_d = speed_q + 1'b1;
              if (speed_d == target_d) state_d = RUN;
            end
          end
        end
        HOLD: begin
          if (run) state_d = (speed_q < target_q) ? RAMP : RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    ramping_d = (speed_d != target_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      level_q    <= '0;
      hit_cnt_q  <= '0;
      speed_q    <= BASE;
      target_q   <= BASE;
      level_up_q <= 1'b0;
      ramping_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      hit_cnt_q  <= hit_cnt_d;
      speed_q    <= speed_d;
      target_q   <= target_d;
      level_up_q <= level_up_d;
      ramping_q  <= ramping_d;
    end
  end

  assign speed    = speed_q;
  assign level    = level_q;
  assign level_up = level_up_q;
  assign ramping  = ramping_q;

endmodule

// File: tb/tb_bounce_level_ctrl.sv
// Directed bench for bounce_level_ctrl with default parameters.
module tb_bounce_level_ctrl;
  import bounce_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic       game_clr = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] speed;
  logic [3:0] level;
  logic       level_up;
  logic       ramping;

  int n_asserts = 0;
  int n_fail    = 0;
  int lu_cnt    = 0;

  bounce_level_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run        (run),
    .game_clr   (game_clr),
    .hit        (hit),
    .miss       (miss),
    .speed      (speed),
    .level      (level),
    .level_up   (level_up),
    .ramping    (ramping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (level_up === 1'b1) lu_cnt++;
  endtask

  task automatic do_hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; cyc(); hit = 1'b0;
    end
  endtask

  task automatic do_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    end
  endtask

  initial begin
    // Reset values
    cyc(); cyc();
    chk("rst_speed", 8'(speed), 8'd1);
    chk("rst_level", 8'(level), 8'd0);
    chk("rst_lvlup", 8'(level_up), 8'd0);
    chk("rst_ramping", 8'(ramping), 8'd0);
    reset = 1'b0;

    // First level-up and full ramp
    run = 1'b1; cyc();
    chk("idle_to_run", 8'(dut.state_q), 8'(RUN));
    do_hits(4);
    chk("four_hits_lvl", 8'(level), 8'd0);
    hit = 1'b1; cyc(); hit = 1'b0;
    chk("l1_level", 8'(level), 8'd1);
    chk("l1_pulse", 8'(level_up), 8'd1);
    chk("l1_ramping", 8'(ramping), 8'd1);
    chk("l1_target", 8'(dut.target_q), 8'd2);
    chk("l1_state", 8'(dut.state_q), 8'(RAMP));
    do_frames(1);
    chk("l1_pulse_end", 8'(level_up), 8'd0);
    do_frames(28);
    chk("l1_speed_29", 8'(speed), 8'd1);
    do_frames(1);
    chk("l1_speed_30", 8'(speed), 8'd2);
    chk("l1_ramp_done", 8'(ramping), 8'd0);
    chk("l1_run", 8'(dut.state_q), 8'(RUN));
    do_frames(40);
    chk("run_ignores_tick", 8'(speed), 8'd2);

    // Level-up then miss after 10 ticks: snap and hold
    do_hits(5);
    chk("l2_level", 8'(level), 8'd2);
    do_frames(10);
    chk("l2_speed_mid", 8'(speed), 8'd2);
    chk("l2_fcnt", 8'(dut.u_div.cnt_o), 8'd10);
    miss = 1'b1; run = 1'b0; cyc(); miss = 1'b0;
    chk("snap_speed", 8'(speed), 8'd3);
    chk("snap_hold", 8'(dut.state_q), 8'(HOLD));
    chk("snap_ramping", 8'(ramping), 8'd0);
    do_hits(5);
    chk("hold_ign_hits", 8'(level), 8'd2);
    run = 1'b1; cyc();
    chk("hold_to_run", 8'(dut.state_q), 8'(RUN));

    // Simultaneous hit+miss at hit_cnt=4
    do_hits(4);
    hit = 1'b1; miss = 1'b1; cyc(); hit = 1'b0; miss = 1'b0;
    chk("hm_level", 8'(level), 8'd2);
    chk("hm_pulse", 8'(level_up), 8'd0);
    chk("hm_hold", 8'(dut.state_q), 8'(HOLD));
    cyc();
    chk("hm_resume", 8'(dut.state_q), 8'(RUN));
    do_hits(1);
    chk("hm_kept_cnt", 8'(level), 8'd3);

    // Mid-ramp pause freezes speed and frame count
    do_frames(12);
    chk("pause_fcnt0", 8'(dut.u_div.cnt_o), 8'd12);
    run = 1'b0; cyc();
    do_frames(100);
    chk("pause_speed", 8'(speed), 8'd3);
    chk("pause_fcnt", 8'(dut.u_div.cnt_o), 8'd12);
    chk("pause_hold", 8'(dut.state_q), 8'(HOLD));
    chk("pause_ramping", 8'(ramping), 8'd1);
    run = 1'b1; cyc();
    chk("pause_resume", 8'(dut.state_q), 8'(RAMP));
    do_frames(17);
    chk("resume_speed17", 8'(speed), 8'd3);
    do_frames(1);
    chk("resume_speed18", 8'(speed), 8'd4);
    chk("resume_run", 8'(dut.state_q), 8'(RUN));

    // game_clr mid-ramp at level 3
    game_clr = 1'b1; cyc(); game_clr = 1'b0;
    chk("clr0_level", 8'(level), 8'd0);
    cyc();
    do_hits(15);
    chk("clr_pre_level", 8'(level), 8'd3);
    chk("clr_pre_ramp", 8'(ramping), 8'd1);
    do_frames(3);
    game_clr = 1'b1; cyc(); game_clr = 1'b0;
    chk("clr_level", 8'(level), 8'd0);
    chk("clr_speed", 8'(speed), 8'd1);
    chk("clr_ramping", 8'(ramping), 8'd0);
    chk("clr_state", 8'(dut.state_q), 8'(IDLE));
    chk("clr_fcnt", 8'(dut.u_div.cnt_o), 8'd0);

    // Async reset mid-ramp right after a level-up pulse
    cyc();
    do_hits(15);
    chk("rst_pre_pulse", 8'(level_up), 8'd1);
    reset = 1'b1; #1;
    chk("arst_level", 8'(level), 8'd0);
    chk("arst_speed", 8'(speed), 8'd1);
    chk("arst_ramping", 8'(ramping), 8'd0);
    chk("arst_pulse", 8'(level_up), 8'd0);
    chk("arst_state", 8'(dut.state_q), 8'(IDLE));
    cyc();
    reset = 1'b0;

    // Saturation: 50 hits with plenty of frame ticks between
    lu_cnt = 0;
    cyc();
    for (int i = 0; i < 50; i++) begin
      do_hits(1);
      do_frames(40);
    end
    chk("sat_level", 8'(level), 8'd9);
    chk("sat_speed", 8'(speed), 8'd10);
    chk("sat_pulses", 8'(lu_cnt), 8'd9);
    chk("sat_ramping", 8'(ramping), 8'd0);
    chk("sat_hitcnt", 8'(dut.hit_cnt_q), 8'd0);
    do_hits(5);
    chk("sat_hold_lvl", 8'(level), 8'd9);
    chk("sat_no_pulse", 8'(lu_cnt), 8'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
